// File: rtl/hw_qsys_pio_gen2_pkg.sv
//------------------------------------------------------------------------------
// Module   : hw_qsys_pio_pkg
// Purpose  : Register map, edge-mode encodings and edge helper for the PIO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hw_qsys_pio_pkg;

    localparam logic [2:0] PIO_DATA    = 3'd0;
    localparam logic [2:0] PIO_DIR     = 3'd1;
    localparam logic [2:0] PIO_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_EDGECAP = 3'd3;
    localparam logic [2:0] PIO_OUTSET  = 3'd4;
    localparam logic [2:0] PIO_OUTCLR  = 3'd5;

    localparam logic [1:0] EDGE_RISING  = 2'd0;
    localparam logic [1:0] EDGE_FALLING = 2'd1;
    localparam logic [1:0] EDGE_ANY     = 2'd2;

    function automatic logic edge_hit(input logic cur, input logic prev, input logic [1:0] mode);
        case (mode)
            EDGE_FALLING: return ~cur & prev;
            EDGE_ANY:     return cur ^ prev;
            default:      return cur & ~prev;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/hw_qsys_pio_gen2_if.sv
//------------------------------------------------------------------------------
// Module   : hw_qsys_pio_gen2_if
// Purpose  : Avalon-MM slave bus plus interrupt line of the PIO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hw_qsys_pio_gen2_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

`default_nettype wire

// File: rtl/hw_qsys_pio_gen2_sync_edge.sv
//------------------------------------------------------------------------------
// Module   : hw_qsys_pio_sync_edge
// Purpose  : Input synchroniser, previous-value register, arm counter, edges.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hw_qsys_pio_sync_edge
    import hw_qsys_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [DATA_WIDTH-1:0] i_pio_in,
    output logic      [DATA_WIDTH-1:0] o_sync_in,
    output logic      [DATA_WIDTH-1:0] o_edges
);

    localparam logic [2:0] c_ARM_CYCLES = 3'(SYNC_STAGES + 1);
    localparam logic [1:0] c_EDGE_MODE  = 2'(EDGE_TYPE);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
    logic [DATA_WIDTH-1:0]                  r_prev;
    logic [2:0]                             r_arm_cnt;
    logic                                   w_armed;

    // Edges are masked until the chain has flushed its reset zeros, so a pin
    // already high at reset release never looks like a fresh rising edge.
    assign w_armed   = (r_arm_cnt == c_ARM_CYCLES);
    assign o_sync_in = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_prev    <= '0;
            r_arm_cnt <= '0;
        end else begin
            r_sync[0] <= i_pio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 3'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            assign o_edges[gi] = w_armed & edge_hit(r_sync[SYNC_STAGES-1][gi], r_prev[gi], c_EDGE_MODE);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/hw_qsys_pio_gen2.sv
//------------------------------------------------------------------------------
// Module   : hw_qsys_pio_gen2
// Purpose  : Avalon-MM PIO with per-bit direction, set/clear, edge capture, irq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hw_qsys_pio_gen2
    import hw_qsys_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    hw_qsys_pio_gen2_if.slave          bus,
    input  wire logic [DATA_WIDTH-1:0] pio_in,
    output logic      [DATA_WIDTH-1:0] pio_out,
    output logic      [DATA_WIDTH-1:0] pio_oe
);

    localparam logic [31:0] c_MASK = 32'({DATA_WIDTH{1'b1}});

    logic [31:0]           r_data_out;
    logic [31:0]           r_dir;
    logic [31:0]           r_irqmask;
    logic [31:0]           r_edgecap;
    logic [31:0]           r_readdata;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] w_sync_in;
    logic [DATA_WIDTH-1:0] w_edges;
    logic [31:0]           w_sync32;
    logic [31:0]           w_wd;
    logic [31:0]           w_clr;
    logic [31:0]           w_edgecap_next;
    logic [31:0]           w_rd_data;
    logic                  w_wr;
    logic                  w_rd;

    hw_qsys_pio_sync_edge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .i_pio_in  (pio_in),
        .o_sync_in (w_sync_in),
        .o_edges   (w_edges)
    );

    assign w_wr     = bus.chipselect & ~bus.write_n;
    assign w_rd     = bus.chipselect &  bus.write_n;
    assign w_wd     = bus.writedata & c_MASK;
    assign w_sync32 = 32'(w_sync_in);

    // A new edge is OR-ed in after the W1C so it survives a same-cycle clear.
    assign w_clr          = (w_wr && bus.address == PIO_EDGECAP) ? w_wd : 32'd0;
    assign w_edgecap_next = (r_edgecap & ~w_clr) | 32'(w_edges);

    always_comb begin
        w_rd_data = 32'd0;
        case (bus.address)
            PIO_DATA:    w_rd_data = (r_dir & r_data_out) | (~r_dir & w_sync32);
            PIO_DIR:     w_rd_data = r_dir;
            PIO_IRQMASK: w_rd_data = r_irqmask;
            PIO_EDGECAP: w_rd_data = r_edgecap;
            default:     w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= 32'(OUT_RESET);
            r_dir      <= 32'(DIR_RESET);
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr) begin
                case (bus.address)
                    PIO_DATA:    r_data_out <= w_wd;
                    PIO_DIR:     r_dir      <= w_wd;
                    PIO_IRQMASK: r_irqmask  <= w_wd;
                    PIO_OUTSET:  r_data_out <= r_data_out | w_wd;
                    PIO_OUTCLR:  r_data_out <= r_data_out & ~w_wd;
                    default:     ;
                endcase
            end
            r_edgecap <= w_edgecap_next;
            r_irq     <= |(w_edgecap_next & r_irqmask);
            if (w_rd) begin
                r_readdata <= w_rd_data;
            end
        end
    end

    assign pio_out      = r_data_out[DATA_WIDTH-1:0];
    assign pio_oe       = r_dir[DATA_WIDTH-1:0];
    assign bus.readdata = r_readdata;
    assign bus.irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_hw_qsys_pio_gen2.sv
//------------------------------------------------------------------------------
// Module   : tb_hw_qsys_pio_gen2
// Purpose  : Directed self-checking bench for hw_qsys_pio_gen2 (8-bit build).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hw_qsys_pio_gen2;
    import hw_qsys_pio_pkg::*;

    localparam int         c_DW        = 8;
    localparam logic [7:0] c_OUT_RESET = 8'h5A;
    localparam logic [7:0] c_DIR_RESET = 8'h00;

    logic             clk;
    logic             reset;
    logic [c_DW-1:0]  pio_in;
    logic [c_DW-1:0]  pio_out;
    logic [c_DW-1:0]  pio_oe;
    logic [31:0]      q_exp[$];
    int               n_tests;
    int               n_fail;

    hw_qsys_pio_gen2_if bus_if ();

    hw_qsys_pio_gen2 #(
        .DATA_WIDTH  (c_DW),
        .OUT_RESET   (c_OUT_RESET),
        .DIR_RESET   (c_DIR_RESET),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if.slave),
        .pio_in  (pio_in),
        .pio_out (pio_out),
        .pio_oe  (pio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    // Expected value is queued at the strobe and retired one edge later.
    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        q_exp.push_back(exp);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = a;
        tick();
        bus_if.chipselect = 1'b0;
        e = q_exp.pop_front();
        check(tag, bus_if.readdata, e);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        pio_in  = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = '0;
        bus_if.writedata  = '0;
        #1;
        check("rst_pio_out", 32'(pio_out), 32'(c_OUT_RESET));
        check("rst_pio_oe", 32'(pio_oe), 32'(c_DIR_RESET));
        check("rst_readdata", bus_if.readdata, 32'd0);
        check("rst_irq", 32'(bus_if.irq), 32'd0);
        ticks(2);
        reset = 1'b0;
        ticks(2);

        // Basic data/direction and read latency
        bus_write(PIO_DATA, 32'hFFFF_FFA5);
        bus_write(PIO_DIR, 32'h0000_00FF);
        check("t1_pio_out", 32'(pio_out), 32'hA5);
        check("t1_pio_oe", 32'(pio_oe), 32'hFF);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = PIO_DATA;
        #2;
        check("t1_rd_not_early", bus_if.readdata, 32'd0);
        bus_if.chipselect = 1'b0;
        bus_read(PIO_DATA, 32'hA5, "t1_rd_data");
        tick();
        check("t1_rd_hold", bus_if.readdata, 32'hA5);

        // Atomic set/clear and unused addresses
        bus_write(PIO_OUTSET, 32'h0F);
        check("t2_outset", 32'(pio_out), 32'hAF);
        bus_write(PIO_OUTCLR, 32'h81);
        check("t2_outclr", 32'(pio_out), 32'h2E);
        for (int a = 4; a < 8; a++) begin
            bus_read(3'(a), 32'd0, $sformatf("t2_rd_addr%0d", a));
        end
        bus_read(PIO_DIR, 32'hFF, "t2_rd_dir");
        bus_write(3'd6, 32'hFF);
        check("t2_addr6_ignored", 32'(pio_out), 32'h2E);

        // Mixed direction readback through the synchroniser
        bus_write(PIO_DIR, 32'h0F);
        bus_write(PIO_DATA, 32'h0F);
        pio_in = 8'hC0;
        ticks(3);
        bus_read(PIO_DATA, 32'hCF, "t3_rd_mixed");
        bus_read(PIO_EDGECAP, 32'hC0, "t3_edgecap_input_bits");
        bus_write(PIO_EDGECAP, 32'hFF);
        bus_read(PIO_EDGECAP, 32'h00, "t3_edgecap_w1c");
        check("t3_irq_masked", 32'(bus_if.irq), 32'd0);

        // Rising edge on bit 0: capture after 3 edges, irq, then W1C
        bus_write(PIO_IRQMASK, 32'h01);
        pio_in = 8'hC1;
        ticks(2);
        bus_read(PIO_EDGECAP, 32'h00, "t4_edgecap_before");
        bus_read(PIO_EDGECAP, 32'h01, "t4_edgecap_set");
        check("t4_irq_set", 32'(bus_if.irq), 32'd1);
        bus_write(PIO_EDGECAP, 32'h01);
        tick();
        check("t4_irq_cleared", 32'(bus_if.irq), 32'd0);
        bus_read(PIO_EDGECAP, 32'h00, "t4_edgecap_cleared");

        // W1C coinciding with a fresh rising edge: edge wins
        pio_in = 8'hC0;
        ticks(3);
        check("t5_fall_no_irq", 32'(bus_if.irq), 32'd0);
        pio_in = 8'hC1;
        ticks(4);
        check("t5_irq_first", 32'(bus_if.irq), 32'd1);
        pio_in = 8'hC0;
        ticks(3);
        pio_in = 8'hC1;
        ticks(2);
        bus_write(PIO_EDGECAP, 32'h01);
        check("t5_irq_after_w1c", 32'(bus_if.irq), 32'd1);
        tick();
        check("t5_irq_stays", 32'(bus_if.irq), 32'd1);
        bus_read(PIO_EDGECAP, 32'h01, "t5_edgecap_stays");
        bus_write(PIO_IRQMASK, 32'h00);
        tick();
        check("t5_irq_mask_off", 32'(bus_if.irq), 32'd0);

        // Pins high through reset never capture
        pio_in = 8'hFF;
        reset  = 1'b1;
        ticks(2);
        reset = 1'b0;
        check("t6_pio_out_rst", 32'(pio_out), 32'(c_OUT_RESET));
        ticks(20);
        bus_read(PIO_EDGECAP, 32'h00, "t6_no_spurious_edge");

        // Reset arriving in the middle of a read
        bus_write(PIO_DIR, 32'hFF);
        bus_write(PIO_DATA, 32'h77);
        bus_read(PIO_DATA, 32'h77, "t6_rd_before_reset");
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = PIO_DATA;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_readdata", bus_if.readdata, 32'd0);
        check("t6_async_pio_out", 32'(pio_out), 32'(c_OUT_RESET));
        check("t6_async_pio_oe", 32'(pio_oe), 32'(c_DIR_RESET));
        bus_if.chipselect = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("t6_read_discarded", bus_if.readdata, 32'd0);
        check("sb_queue_empty", 32'(q_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
